// File: rtl/pipe_regfile.sv
`default_nettype none
// ============================================================================
// Module      : pipe_regfile
// Description : Register file with a per-register busy scoreboard, two
//               combinational read ports and one writeback port. When the
//               macro PIPE_REGFILE_BYPASS_EN is defined, a same-cycle
//               writeback is forwarded to the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    output logic              hazard
);

    localparam int c_DEPTH = 2 ** ADDR_W;
    localparam int c_PORTS = 2;

    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [c_DEPTH-1:0] r_busy;
    logic [c_DEPTH-1:0] w_busy_next;

    logic               w_wr_ok;
    logic               w_issue_ok;

    logic [ADDR_W-1:0]  w_rd_addr [c_PORTS];
    logic [DATA_W-1:0]  w_rd_data [c_PORTS];
    logic               w_rd_busy [c_PORTS];

    // Register 0 is hardwired when ZERO_REG is set; a flush suppresses issue.
    assign w_wr_ok    = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    assign w_issue_ok = issue_en && !flush && !((ZERO_REG != 0) && (issue_addr == '0));

    // Issue is applied after writeback so a coincident re-issue keeps the bit set.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_ok) begin
            w_busy_next[wr_addr] = 1'b0;
        end
        if (w_issue_ok) begin
            w_busy_next[issue_addr] = 1'b1;
        end
        if (flush) begin
            w_busy_next = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[wr_addr] <= wr_data;
            end
            r_busy <= w_busy_next;
        end
    end

    assign w_rd_addr[0] = rd_addr_a;
    assign w_rd_addr[1] = rd_addr_b;

    for (genvar gp = 0; gp < c_PORTS; gp++) begin : g_port
        always_comb begin
            w_rd_data[gp] = r_mem[w_rd_addr[gp]];
            w_rd_busy[gp] = r_busy[w_rd_addr[gp]];
`ifdef PIPE_REGFILE_BYPASS_EN
            // Forwarded data is ready now; only a coincident re-issue keeps it busy.
            if (w_wr_ok && (wr_addr == w_rd_addr[gp])) begin
                w_rd_data[gp] = wr_data;
                w_rd_busy[gp] = w_issue_ok && (issue_addr == w_rd_addr[gp]);
            end
`endif
            if ((ZERO_REG != 0) && (w_rd_addr[gp] == '0)) begin
                w_rd_data[gp] = '0;
                w_rd_busy[gp] = 1'b0;
            end
        end
    end

    assign rd_data_a = w_rd_data[0];
    assign rd_data_b = w_rd_data[1];
    assign busy_a    = w_rd_busy[0];
    assign busy_b    = w_rd_busy[1];
    assign hazard    = busy_a | busy_b;

endmodule
`default_nettype wire

// File: tb/tb_pipe_regfile.sv
`default_nettype none
// Directed self-checking bench for pipe_regfile; a second instance runs with ZERO_REG=0.
module tb_pipe_regfile;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        flush;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        busy_a, busy_b, hazard;
    logic [31:0] nz_rd_data_a, nz_rd_data_b;
    logic        nz_busy_a, nz_busy_b, nz_hazard;

    int vectors = 0;
    int errs    = 0;

    pipe_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .busy_a(busy_a), .busy_b(busy_b), .hazard(hazard)
    );

    pipe_regfile #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(nz_rd_data_a), .rd_data_b(nz_rd_data_b),
        .busy_a(nz_busy_a), .busy_b(nz_busy_b), .hazard(nz_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow immediately.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
        rd_addr_a = 5'd5; rd_addr_b = 5'd6;

        // Power-on reset, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("por_data_a", rd_data_a, 32'h0);
        chk("por_busy_a", {31'b0, busy_a}, 32'h0);
        chk("por_hazard", {31'b0, hazard}, 32'h0);
        tick();
        reset = 1'b0;

        // Write r5 and issue r6, then asynchronous reset mid-cycle
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        issue_en = 1'b1; issue_addr = 5'd6;
        tick();
        wr_en = 1'b0; issue_en = 1'b0;
        chk("r5_written", rd_data_a, 32'hDEADBEEF);
        chk("r6_busy", {31'b0, busy_b}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_r5", rd_data_a, 32'h0);
        chk("async_rst_busy6", {31'b0, busy_b}, 32'h0);
        chk("async_rst_hazard", {31'b0, hazard}, 32'h0);

        // Write coincident with reset is lost
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h00000001;
        tick();
        wr_en = 1'b0; reset = 1'b0;
        #1;
        chk("rst_write_lost", rd_data_a, 32'h0);

        // Issue r7, write it two cycles later
        issue_en = 1'b1; issue_addr = 5'd7;
        rd_addr_a = 5'd7; rd_addr_b = 5'd0;
        tick();
        issue_en = 1'b0;
        chk("r7_busy_c1", {31'b0, busy_a}, 32'h1);
        chk("r7_hazard_c1", {31'b0, hazard}, 32'h1);
        tick();
        chk("r7_busy_c2", {31'b0, busy_a}, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        #1;
`ifdef PIPE_REGFILE_BYPASS_EN
        chk("r7_pre_edge_data", rd_data_a, 32'h12345678);
        chk("r7_pre_edge_busy", {31'b0, busy_a}, 32'h0);
        chk("r7_pre_edge_hazard", {31'b0, hazard}, 32'h0);
`else
        chk("r7_pre_edge_data", rd_data_a, 32'h0);
        chk("r7_pre_edge_busy", {31'b0, busy_a}, 32'h1);
        chk("r7_pre_edge_hazard", {31'b0, hazard}, 32'h1);
`endif
        tick();
        wr_en = 1'b0;
        chk("r7_post_data", rd_data_a, 32'h12345678);
        chk("r7_post_busy", {31'b0, busy_a}, 32'h0);
        chk("r7_post_hazard", {31'b0, hazard}, 32'h0);

        // Write and re-issue r3 in the same cycle
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h000000A5;
        issue_en = 1'b1; issue_addr = 5'd3;
        tick();
        wr_en = 1'b0; issue_en = 1'b0;
        rd_addr_a = 5'd3; rd_addr_b = 5'd3;
        #1;
        chk("r3_data_a", rd_data_a, 32'h000000A5);
        chk("r3_busy_a", {31'b0, busy_a}, 32'h1);
        chk("r3_data_b", rd_data_b, 32'h000000A5);
        chk("r3_busy_b", {31'b0, busy_b}, 32'h1);

        // Write r11 while issuing r12: independent
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h00000077;
        issue_en = 1'b1; issue_addr = 5'd12;
        tick();
        wr_en = 1'b0; issue_en = 1'b0;
        rd_addr_a = 5'd11; rd_addr_b = 5'd12;
        #1;
        chk("r11_data", rd_data_a, 32'h00000077);
        chk("r11_busy", {31'b0, busy_a}, 32'h0);
        chk("r12_busy", {31'b0, busy_b}, 32'h1);

        // Issue r1, r2, r9 then flush with coincident issue r4 and write r13
        issue_en = 1'b1; issue_addr = 5'd1;
        tick();
        issue_addr = 5'd2;
        tick();
        issue_addr = 5'd9;
        tick();
        issue_en = 1'b0;
        rd_addr_a = 5'd9; rd_addr_b = 5'd1;
        #1;
        chk("r9_busy_pre_flush", {31'b0, busy_a}, 32'h1);
        chk("r1_busy_pre_flush", {31'b0, busy_b}, 32'h1);
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'h0000BEEF;
        tick();
        flush = 1'b0; issue_en = 1'b0; wr_en = 1'b0;
        chk("flush_r9", {31'b0, busy_a}, 32'h0);
        chk("flush_r1", {31'b0, busy_b}, 32'h0);
        rd_addr_a = 5'd4; rd_addr_b = 5'd2;
        #1;
        chk("flush_r4", {31'b0, busy_a}, 32'h0);
        chk("flush_r2", {31'b0, busy_b}, 32'h0);
        rd_addr_a = 5'd3; rd_addr_b = 5'd13;
        #1;
        chk("flush_r3", {31'b0, busy_a}, 32'h0);
        chk("flush_r13_data", rd_data_b, 32'h0000BEEF);
        chk("flush_hazard", {31'b0, hazard}, 32'h0);

        // Register 0: hardwired with ZERO_REG=1, ordinary with ZERO_REG=0
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_addr = 5'd0;
        #1;
        chk("r0_pre_edge_data", rd_data_a, 32'h0);
        tick();
        wr_en = 1'b0; issue_en = 1'b0;
        chk("r0_zero_data", rd_data_a, 32'h0);
        chk("r0_zero_busy", {31'b0, busy_a}, 32'h0);
        chk("r0_nz_data", nz_rd_data_a, 32'hFFFFFFFF);
        chk("r0_nz_busy", {31'b0, nz_busy_a}, 32'h1);

        // r10: old value 0x1111 and busy, then written with 0x55AA
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h00001111;
        tick();
        wr_en = 1'b0;
        issue_en = 1'b1; issue_addr = 5'd10;
        tick();
        issue_en = 1'b0;
        rd_addr_a = 5'd10; rd_addr_b = 5'd10;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h000055AA;
        #1;
`ifdef PIPE_REGFILE_BYPASS_EN
        chk("r10_same_data_a", rd_data_a, 32'h000055AA);
        chk("r10_same_data_b", rd_data_b, 32'h000055AA);
        chk("r10_same_busy_a", {31'b0, busy_a}, 32'h0);
        chk("r10_same_busy_b", {31'b0, busy_b}, 32'h0);
`else
        chk("r10_same_data_a", rd_data_a, 32'h00001111);
        chk("r10_same_data_b", rd_data_b, 32'h00001111);
        chk("r10_same_busy_a", {31'b0, busy_a}, 32'h1);
        chk("r10_same_busy_b", {31'b0, busy_b}, 32'h1);
`endif
        tick();
        wr_en = 1'b0;
        chk("r10_post_data_a", rd_data_a, 32'h000055AA);
        chk("r10_post_data_b", rd_data_b, 32'h000055AA);
        chk("r10_post_busy", {31'b0, busy_a}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_regfile.md
PIPE_REGFILE -- requirements
Module: pipe_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads zero, ignores writes and is never busy.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears data array and scoreboard.
REQ-006 wr_en  input  1  writeback strobe.
REQ-007 wr_addr  input  ADDR_W  writeback destination.
REQ-008 wr_data  input  DATA_W  writeback value.
REQ-009 issue_en  input  1  instruction issued that will later write issue_addr.
REQ-010 issue_addr  input  ADDR_W  destination marked pending.
REQ-011 flush  input  1  synchronous clear of all busy bits; data untouched.
REQ-012 rd_addr_a, rd_addr_b  input  ADDR_W each  read addresses.
REQ-013 rd_data_a, rd_data_b  output  DATA_W each  combinational read data.
REQ-014 busy_a, busy_b  output  1 each  read operand has pending write not yet visible.
REQ-015 hazard  output  1  busy_a OR busy_b.

Function
REQ-016 Read ports SHALL be combinational from rd_addr and array/scoreboard state; zero-cycle latency.
REQ-017 On rising clk with wr_en=1 (and wr_addr!=0 when ZERO_REG=1), array[wr_addr] SHALL take wr_data.
REQ-018 Busy bit of wr_addr SHALL clear on a write edge unless issue_en=1 with issue_addr==wr_addr in the same cycle, in which case it SHALL remain set (new issue wins).
REQ-019 issue_en=1 SHALL set busy[issue_addr] on the edge; ignored for address 0 when ZERO_REG=1.
REQ-020 flush=1 SHALL clear all busy bits on the edge, overriding issue_en in that cycle; a coincident write still updates data.
REQ-021 Address 0 with ZERO_REG=1 SHALL read 0 and busy 0 regardless of any input, including bypass.
REQ-022 Same-cycle write-then-issue to different addresses SHALL be independent; both take effect.
REQ-023 busy_x SHALL equal busy[rd_addr_x] except as modified by REQ-026.
REQ-024 Both read ports addressing the same register SHALL return identical data and busy.

Reset
REQ-025 While reset=1, all array entries SHALL be 0, all busy bits 0, hence rd_data_* 0, busy_* 0, hazard 0, independent of clk; a write or issue coincident with reset assertion SHALL be lost.

Configuration
REQ-026 Macro PIPE_REGFILE_BYPASS_EN defined: when wr_en=1 and wr_addr==rd_addr_x (non-zero if ZERO_REG=1), rd_data_x SHALL equal wr_data and busy_x SHALL be 0 in that same cycle, unless flush=0, issue_en=1 and issue_addr==rd_addr_x (then busy_x reports the post-edge busy, i.e. 1). Undefined: no forwarding; rd_data_x and busy_x reflect pre-edge state; written value visible from the next cycle.

Verification
REQ-027 Reset mid-run after writing 0xDEADBEEF to r5: assert reset asynchronously -> rd_data_a(r5)=0 before next clk edge, all busy 0.
REQ-028 issue r7; two cycles later write r7=0x12345678 -> busy_a(r7)=1, hazard=1 until the write edge; after it, data 0x12345678, busy 0.
REQ-029 Same cycle wr r3=0xA5 and issue r3 -> after edge rd_data r3=0xA5, busy_a(r3)=1.
REQ-030 Write r0=0xFFFFFFFF and issue r0 with ZERO_REG=1 -> rd_data r0=0, busy 0; ZERO_REG=0 -> r0 reads 0xFFFFFFFF.
REQ-031 Issue r1,r2,r9; flush with coincident issue r4 -> all busy 0 including r4.
REQ-032 With bypass: wr r10=0x55AA reading r10 on both ports same cycle -> both ports 0x55AA, busy 0; without bypass -> old value, matching the pre-edge busy state.
